// File: rtl/qft_pkg.sv
// -----------------------------------------------------------------------------
// qft_pkg
// Shared definitions for the qubit-swap streaming engine:
//   - DEFAULT_DATA_W : default signed fixed-point width of one real/imag part,
//                      taken from `TOTAL_WIDTH (fixed_point_params.vh). A
//                      fallback of 16 applies when that header has not been
//                      pulled into the build.
//   - IDX_W          : width used by swap_bits (covers up to 8 index bits).
//   - swap_state_e   : LOAD / EMIT state encoding of the engine FSM.
//   - swap_bits()    : exchanges two bit positions of an amplitude index.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

package qft_pkg;

   localparam int DEFAULT_DATA_W = `TOTAL_WIDTH;
   localparam int MAX_QUBITS     = 6;
   localparam int IDX_W          = 8;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } swap_state_e;

   // Returns k with bit positions a and b exchanged. When a == b the result
   // is k itself, which gives the identity permutation for free.
   function automatic logic [IDX_W-1:0] swap_bits(
      input logic [IDX_W-1:0] k,
      input logic [2:0]       a,
      input logic [2:0]       b
   );
      logic [IDX_W-1:0] r;
      r    = k;
      r[a] = k[b];
      r[b] = k[a];
      return r;
   endfunction

endpackage

// File: rtl/swap_stream_engine_if.sv
// -----------------------------------------------------------------------------
// swap_stream_engine_if
// Amplitude stream bundle for swap_stream_engine.
//   in_valid / in_ready / in_r / in_i            : amplitude input stream
//   out_valid / out_ready / out_r / out_i / out_last : amplitude output stream
// Modports:
//   slave  : the engine (consumes the input stream, produces the output stream)
//   master : the surrounding logic / source-sink side
// Parameter DATA_W: signed width of each real and imaginary part.
// -----------------------------------------------------------------------------
interface swap_stream_engine_if
   import qft_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_r;
   logic signed [DATA_W-1:0] in_i;

   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_r;
   logic signed [DATA_W-1:0] out_i;
   logic                     out_last;

   modport slave (
      input  in_valid, in_r, in_i, out_ready,
      output in_ready, out_valid, out_r, out_i, out_last
   );

   modport master (
      output in_valid, in_r, in_i, out_ready,
      input  in_ready, out_valid, out_r, out_i, out_last
   );

endinterface

// File: rtl/swap_stream_engine_perm.sv
// -----------------------------------------------------------------------------
// swap_index_perm
// Purely combinational index permutation: perm_k_o is k_i with bits qa_i and
// qb_i exchanged. An illegal selection raises sel_err_o and forces identity.
// Optional feature macro: SWAP_CTRL_EN -- adds qc_i; the swap is applied only
// to indices whose bit qc_i is 1 (Fredkin / controlled-SWAP), and qc_i out of
// range or equal to qa_i/qb_i is also illegal.
// Ports:
//   k_i       [NUM_QUBITS-1:0] amplitude index
//   qa_i,qb_i [SEL_W-1:0]      qubit positions to exchange
//   qc_i      [SEL_W-1:0]      control qubit (SWAP_CTRL_EN only)
//   perm_k_o  [NUM_QUBITS-1:0] permuted index
//   sel_err_o                  selection is illegal
// -----------------------------------------------------------------------------
module swap_index_perm
   import qft_pkg::*;
#(
   parameter int NUM_QUBITS = 3,
   parameter int SEL_W      = 2
) (
   input  logic [NUM_QUBITS-1:0] k_i,
   input  logic [SEL_W-1:0]      qa_i,
   input  logic [SEL_W-1:0]      qb_i,
`ifdef SWAP_CTRL_EN
   input  logic [SEL_W-1:0]      qc_i,
`endif
   output logic [NUM_QUBITS-1:0] perm_k_o,
   output logic                  sel_err_o
);

   logic [IDX_W-1:0] k_ext;
   logic [IDX_W-1:0] swapped_full;
   logic             do_swap;
   logic             unused_hi;

   assign k_ext        = IDX_W'(k_i);
   assign swapped_full = swap_bits(k_ext, 3'(qa_i), 3'(qb_i));

   // Upper bits of the fixed-width helper result are always zero-derived.
   assign unused_hi = |swapped_full[IDX_W-1:NUM_QUBITS];

   always_comb begin
      sel_err_o = (int'(qa_i) >= NUM_QUBITS) || (int'(qb_i) >= NUM_QUBITS);
`ifdef SWAP_CTRL_EN
      sel_err_o = sel_err_o || (int'(qc_i) >= NUM_QUBITS) ||
                  (qc_i == qa_i) || (qc_i == qb_i);
`endif
   end

   always_comb begin
      do_swap = !sel_err_o;
`ifdef SWAP_CTRL_EN
      // Controlled swap: only indices with the control bit set are exchanged.
      do_swap = do_swap && k_ext[3'(qc_i)];
`endif
   end

   assign perm_k_o = do_swap ? swapped_full[NUM_QUBITS-1:0] : k_i;

endmodule

// File: rtl/swap_stream_engine.sv
// -----------------------------------------------------------------------------
// swap_stream_engine
// Buffers one frame of 2^NUM_QUBITS complex amplitudes (LOAD), then replays it
// with the amplitude indices permuted by a qubit swap (EMIT). Load and emit do
// not overlap. Data passes bit-exact.
// Optional feature macro: SWAP_CTRL_EN -- adds qc_sel and turns the swap into
// a controlled swap (Fredkin).
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset, priority over handshakes
//   qa_sel, qb_sel qubit indices to swap, latched on the first beat of a frame
//   qc_sel         control qubit index (SWAP_CTRL_EN only), latched likewise
//   cfg_err        one-cycle pulse after the first beat when the selection
//                  is illegal (frame is then emitted unpermuted)
//   bus            swap_stream_engine_if.slave: input and output streams
// -----------------------------------------------------------------------------
module swap_stream_engine
   import qft_pkg::*;
#(
   parameter  int NUM_QUBITS = 3,
   parameter  int DATA_W     = DEFAULT_DATA_W,
   localparam int SEL_W      = (NUM_QUBITS > 2) ? $clog2(NUM_QUBITS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SEL_W-1:0]       qa_sel,
   input  logic [SEL_W-1:0]       qb_sel,
`ifdef SWAP_CTRL_EN
   input  logic [SEL_W-1:0]       qc_sel,
`endif
   output logic                   cfg_err,
   swap_stream_engine_if.slave    bus
);

   localparam int                    DEPTH  = 1 << NUM_QUBITS;
   localparam logic [NUM_QUBITS-1:0] LAST_K = NUM_QUBITS'(DEPTH - 1);

   swap_state_e           state_q, state_d;
   logic [NUM_QUBITS-1:0] k_q, k_d;
   logic [SEL_W-1:0]      qa_q, qb_q;
`ifdef SWAP_CTRL_EN
   logic [SEL_W-1:0]      qc_q;
`endif
   logic                  first_beat_q;

   logic                  in_ready_c;
   logic                  out_valid_c;
   logic                  out_last_c;
   logic                  in_acc;
   logic                  first_acc;
   logic [NUM_QUBITS-1:0] perm_k;
   logic                  sel_err;

   logic signed [DATA_W-1:0] buf_r [DEPTH];
   logic signed [DATA_W-1:0] buf_i [DEPTH];

   assign in_acc    = bus.in_valid & in_ready_c;
   assign first_acc = in_acc && (k_q == '0);

   // ---------------- FSM: next state and handshake outputs ----------------
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      out_last_c  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               k_d = k_q + 1'b1;
               if (k_q == LAST_K) begin
                  state_d = ST_EMIT;
                  k_d     = '0;
               end
            end
         end
         ST_EMIT: begin
            out_valid_c = 1'b1;
            out_last_c  = (k_q == LAST_K);
            if (bus.out_ready) begin
               k_d = k_q + 1'b1;
               if (k_q == LAST_K) begin
                  state_d = ST_LOAD;
                  k_d     = '0;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            k_d     = '0;
         end
      endcase
   end

   // ---------------- FSM and selection registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         k_q          <= '0;
         first_beat_q <= 1'b0;
         qa_q         <= '0;
         qb_q         <= '0;
`ifdef SWAP_CTRL_EN
         qc_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         first_beat_q <= first_acc;
         // Selection is frozen for the whole frame from its first beat.
         if (first_acc) begin
            qa_q <= qa_sel;
            qb_q <= qb_sel;
`ifdef SWAP_CTRL_EN
            qc_q <= qc_sel;
`endif
         end
      end
   end

   // ---------------- Frame buffer (no reset needed on contents) ----------------
   always_ff @(posedge clk) begin
      if (!rst && in_acc) begin
         buf_r[k_q] <= bus.in_r;
         buf_i[k_q] <= bus.in_i;
      end
   end

   // ---------------- Index permutation ----------------
   swap_index_perm #(
      .NUM_QUBITS (NUM_QUBITS),
      .SEL_W      (SEL_W)
   ) u_perm (
      .k_i       (k_q),
      .qa_i      (qa_q),
      .qb_i      (qb_q),
`ifdef SWAP_CTRL_EN
      .qc_i      (qc_q),
`endif
      .perm_k_o  (perm_k),
      .sel_err_o (sel_err)
   );

   // ---------------- Outputs ----------------
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_last  = out_last_c;
   // Outputs read zero outside EMIT so the reset state is fully defined.
   assign bus.out_r     = (state_q == ST_EMIT) ? buf_r[perm_k] : '0;
   assign bus.out_i     = (state_q == ST_EMIT) ? buf_i[perm_k] : '0;
   // The latched selection is visible the cycle after the first beat.
   assign cfg_err       = first_beat_q & sel_err;

endmodule

// File: tb/tb_swap_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_swap_stream_engine
// Directed bench for swap_stream_engine (NUM_QUBITS=3). Frames carry
// r = base+k, i = -(base+k); expected output orders are hand-computed tables.
// Optional feature macro: SWAP_CTRL_EN (adds qc_sel and the Fredkin case).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_swap_stream_engine;
   import qft_pkg::*;

   localparam int N  = 3;
   localparam int DW = DEFAULT_DATA_W;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] qa_sel;
   logic [SW-1:0] qb_sel;
`ifdef SWAP_CTRL_EN
   logic [SW-1:0] qc_sel;
`endif
   logic          cfg_err;

   int n_total    = 0;
   int n_bad      = 0;
   int err_pulses = 0;

   int seq_id     [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
   int seq_swap02 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   int seq_swap12 [8] = '{0, 1, 4, 5, 2, 3, 6, 7};
   int seq_swap01 [8] = '{0, 2, 1, 3, 4, 6, 5, 7};
`ifdef SWAP_CTRL_EN
   int seq_cswap  [8] = '{0, 1, 2, 3, 4, 6, 5, 7};
`endif

   swap_stream_engine_if #(.DATA_W(DW)) bus ();

   swap_stream_engine #(
      .NUM_QUBITS (N),
      .DATA_W     (DW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .qa_sel  (qa_sel),
      .qb_sel  (qb_sel),
`ifdef SWAP_CTRL_EN
      .qc_sel  (qc_sel),
`endif
      .cfg_err (cfg_err),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cfg_err) err_pulses++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input int base, input int qa, input int qb,
                             input int qc, input int exp_err, input int n_beats);
      qa_sel = SW'(qa);
      qb_sel = SW'(qb);
`ifdef SWAP_CTRL_EN
      qc_sel = SW'(qc);
`else
      if (qc != 0) $display("note: qc=%0d ignored in this build", qc);
`endif
      for (int i = 0; i < n_beats; i++) begin
         if (i == 3) begin
            bus.in_valid = 1'b0;
            tick();
            check("load_gap_ready", int'(bus.in_ready), 1);
         end
         bus.in_valid = 1'b1;
         bus.in_r     = DW'(base + i);
         bus.in_i     = DW'(-(base + i));
         check("load_ready", int'(bus.in_ready), 1);
         check("load_out_valid", int'(bus.out_valid), 0);
         tick();
         if (i == 0) begin
            check("cfg_err_first", int'(cfg_err), exp_err);
            // Mid-frame selection changes must be ignored.
            qa_sel = SW'(qa + 1);
            qb_sel = SW'(qb + 1);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic emit_frame(input int base, input int seq [8],
                             input int stall_beat, input int n_beats);
      for (int j = 0; j < n_beats; j++) begin
         if (j == stall_beat) begin
            bus.out_ready = 1'b0;
            repeat (3) begin
               tick();
               check("stall_hold_r", int'(bus.out_r), base + seq[j]);
               check("stall_valid", int'(bus.out_valid), 1);
            end
            bus.out_ready = 1'b1;
         end
         check("emit_valid", int'(bus.out_valid), 1);
         check("emit_in_ready", int'(bus.in_ready), 0);
         check("emit_r", int'(bus.out_r), base + seq[j]);
         check("emit_i", int'(bus.out_i), -(base + seq[j]));
         check("emit_last", int'(bus.out_last), (j == 7) ? 1 : 0);
         tick();
      end
   endtask

   task automatic run_frame(input int base, input int qa, input int qb, input int qc,
                            input int seq [8], input int exp_err, input int stall_beat);
      err_pulses = 0;
      load_frame(base, qa, qb, qc, exp_err, 8);
      emit_frame(base, seq, stall_beat, 8);
      check("back_in_ready", int'(bus.in_ready), 1);
      check("back_out_valid", int'(bus.out_valid), 0);
      check("cfg_err_pulses", err_pulses, exp_err);
      $display("frame base=%0d qa=%0d qb=%0d qc=%0d stall=%0d checks=%0d bad=%0d",
               base, qa, qb, qc, stall_beat, n_total, n_bad);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, int'(bus.in_ready), 1);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_last"}, int'(bus.out_last), 0);
      check({tag, "_cfg_err"}, int'(cfg_err), 0);
      check({tag, "_out_r"}, int'(bus.out_r), 0);
      check({tag, "_out_i"}, int'(bus.out_i), 0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_r      = '0;
      bus.in_i      = '0;
      bus.out_ready = 1'b1;
      qa_sel        = '0;
      qb_sel        = '0;
`ifdef SWAP_CTRL_EN
      qc_sel        = '0;
`endif
      repeat (2) tick();
      rst = 1'b0;
      check_idle("reset");
      tick();

      run_frame(0, 0, 2, 0, seq_swap02, 0, -1);
      run_frame(0, 1, 1, 0, seq_id, 0, -1);
      run_frame(0, 0, 3, 0, seq_id, 1, -1);
      run_frame(0, 0, 2, 0, seq_swap02, 0, 2);

      // Reset after a partial load: partial frame discarded.
      load_frame(100, 0, 2, 0, 0, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_load");
      $display("reset mid-load applied");
      run_frame(20, 1, 2, 0, seq_swap12, 0, -1);

      // Reset part-way through emission, rst wins over out_ready.
      load_frame(50, 0, 2, 0, 0, 8);
      emit_frame(50, seq_swap02, -1, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_emit");
      $display("reset mid-emit applied");
      run_frame(30, 0, 1, 0, seq_swap01, 0, -1);

`ifdef SWAP_CTRL_EN
      run_frame(0, 0, 1, 2, seq_cswap, 0, -1);
      run_frame(0, 0, 1, 0, seq_id, 1, -1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/swap_stream_engine.md
SWAP_STREAM_ENGINE -- requirements
Module: swap_stream_engine

Interface
REQ-001 SHALL have parameter NUM_QUBITS, default 3, giving the qubit count; the frame length is 2^NUM_QUBITS amplitudes; legal range 2..6.
REQ-002 SHALL have parameter DATA_W, default `TOTAL_WIDTH from fixed_point_params.vh, giving the signed fixed-point width of each real and imaginary part.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports qa_sel and qb_sel, input, $clog2(NUM_QUBITS) bits each (minimum 1 bit): the qubit indices to swap.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_r (input, DATA_W, signed) and in_i (input, DATA_W, signed): the amplitude input stream.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_r (output, DATA_W, signed) and out_i (output, DATA_W, signed): the amplitude output stream.
REQ-008 SHALL have port out_last, output, 1 bit: high on the final output beat of a frame.
REQ-009 SHALL have port cfg_err, output, 1 bit: a one-cycle pulse flagging an illegal qubit selection.

Function
REQ-010 SHALL run a two-state FSM: LOAD (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-011 SHALL, in LOAD, write each accepted beat (in_valid&in_ready) into buffer[k], where k is the beat counter running 0..2^N-1 in arrival order.
REQ-012 SHALL latch qa_sel/qb_sel on the first accepted beat (k=0); selection changes mid-frame SHALL be ignored.
REQ-013 SHALL move to EMIT in the cycle after the beat k=2^N-1 is accepted, with the counter reset to 0; this gives 1-cycle latency from the last input to the first output.
REQ-014 SHALL, in EMIT, drive out_r/out_i = buffer[perm(k)] combinationally from the buffer, where perm(k) is k with bits qa and qb exchanged.
REQ-015 SHALL advance k only on out_valid&out_ready; outputs SHALL hold stable while out_ready=0.
REQ-016 SHALL assert out_last when k=2^N-1; acceptance of that beat SHALL return the FSM to LOAD, with in_ready=1 in the next cycle.
REQ-017 SHALL treat qa==qb as the identity permutation, with no error.
REQ-018 SHALL, if either latched index is >= NUM_QUBITS, pulse cfg_err in the cycle after the k=0 accept and emit the frame unpermuted.
REQ-019 SHALL perform no arithmetic; data SHALL pass bit-exact, with no rounding or saturation.
REQ-020 SHALL NOT overlap load and emit: throughput is one frame per 2*2^N accepted beats.

Reset
REQ-021 SHALL, on rst, set FSM=LOAD, counter=0, out_valid=0, out_last=0, cfg_err=0, out_r=out_i=0 and in_ready=1 from the next cycle.
REQ-022 SHALL, on rst asserted mid-LOAD or mid-EMIT, discard the partial frame; buffer contents need not be cleared.
REQ-023 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-024 SHALL support macro SWAP_CTRL_EN: when defined, add input qc_sel (same width as qa_sel), latched with qa/qb.
REQ-025 SHALL, with SWAP_CTRL_EN, apply the swap only for indices k whose bit qc=1 (controlled-SWAP, Fredkin).
REQ-026 SHALL, with SWAP_CTRL_EN, also flag qc>=N, qc==qa or qc==qb via cfg_err, with identity output.
REQ-027 SHALL, without SWAP_CTRL_EN, have no qc_sel port and apply an unconditional swap.

Structure
REQ-028 SHALL place the FSM state encoding (LOAD/EMIT) and the helper function swap_bits(k, a, b) in shared package qft_pkg.
REQ-029 SHALL take DATA_W defaults from fixed_point_params.vh.
REQ-030 SHALL implement the index permutation in one combinational sub-module, swap_index_perm (inputs k, qa, qb, optional qc; output permuted k).

Verification
REQ-031 SHALL cover: N=3, qa=0, qb=2, input k -> (r=k, i=-k) -> output r-sequence 0,4,2,6,1,5,3,7, i-sequence its negation, out_last on the 8th beat.
REQ-032 SHALL cover: N=3, qa=qb=1, same input -> output 0..7 in order, cfg_err=0.
REQ-033 SHALL cover: N=3, qa=0, qb=3 -> cfg_err pulses once, output 0..7 unpermuted.
REQ-034 SHALL cover: back-pressure, out_ready=0 for 3 cycles on beat 2 -> out_r holds 2 and no beat is lost or duplicated.
REQ-035 SHALL cover: rst asserted after 4 loaded beats -> in_ready=1 and out_valid=0; a fresh frame loads and emits correctly.
REQ-036 SHALL cover, with SWAP_CTRL_EN: qc=2, qa=0, qb=1 -> output 0,1,2,3,4,6,5,7.
